// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider with a valid/ready handshake on
// both sides. It resolves STEPS quotient bits per clock and produces the
// quotient, the remainder and the divide-by-zero / overflow flags.
// Optional feature macro: DIVIDER_SIGNED_EN. When it is defined, is_signed
// selects two's-complement operation. When it is undefined, every operation
// is unsigned and overflow stays 0.
module seq_divider #(
   parameter int unsigned N     = 32,
   parameter int unsigned STEPS = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   input  logic         is_signed,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero,
   output logic         overflow,
   output logic         busy
);

   localparam int unsigned ITERS = N / STEPS;
   localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [N-1:0]       rem;
   logic [N-1:0]       acc;
   logic [N-1:0]       dmag;
   logic [N-1:0]       dividend_mag;
   logic [N-1:0]       divisor_mag;
   logic [N-1:0]       rem_nxt;
   logic [N-1:0]       acc_nxt;
   logic [N:0]         shifted;

`ifdef DIVIDER_SIGNED_EN
   logic signed_op;
   logic neg_q;
   logic neg_r;
   logic ovf;

   // Operand magnitudes; in signed mode, negative operands are negated
   always_comb begin
      signed_op    = is_signed;
      dividend_mag = (signed_op && dividend[N-1]) ? N'(-dividend) : dividend;
      divisor_mag  = (signed_op && divisor[N-1])  ? N'(-divisor)  : divisor;
   end
`else
   logic unused_is_signed;

   // Unsigned-only build: operands are used as magnitudes directly
   always_comb begin
      unused_is_signed = is_signed;
      dividend_mag     = dividend;
      divisor_mag      = divisor;
   end
`endif

   // STEPS restoring sub-steps: shift in the next dividend bit, then subtract if it fits
   always_comb begin
      rem_nxt = rem;
      acc_nxt = acc;
      shifted = '0;
      for (int unsigned i = 0; i < STEPS; i++) begin
         shifted = {rem_nxt, acc_nxt[N-1]};
         if (shifted >= {1'b0, dmag}) begin
            rem_nxt = N'(shifted - {1'b0, dmag});
            acc_nxt = {acc_nxt[N-2:0], 1'b1};
         end else begin
            rem_nxt = shifted[N-1:0];
            acc_nxt = {acc_nxt[N-2:0], 1'b0};
         end
      end
   end

   // Control FSM and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         rem         <= '0;
         acc         <= '0;
         dmag        <= '0;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         ovf         <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  in_ready    <= 1'b0;
                  busy        <= 1'b1;
                  overflow    <= 1'b0;
                  div_by_zero <= (divisor == '0);
                  acc         <= dividend_mag;
                  dmag        <= divisor_mag;
                  rem         <= '0;
                  cnt         <= CNT_W'(ITERS - 1);
`ifdef DIVIDER_SIGNED_EN
                  neg_q <= signed_op && (dividend[N-1] ^ divisor[N-1]);
                  neg_r <= signed_op && dividend[N-1];
                  ovf   <= signed_op && (dividend == {1'b1, {(N-1){1'b0}}})
                           && (divisor == '1);
`endif
                  if (divisor == '0) begin
                     quotient  <= '1;
                     remainder <= dividend;
                     state     <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               rem <= rem_nxt;
               acc <= acc_nxt;
               if (cnt == '0) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            FIX: begin
`ifdef DIVIDER_SIGNED_EN
               quotient  <= neg_q ? N'(-acc) : acc;
               remainder <= neg_r ? N'(-rem) : rem;
               overflow  <= ovf;
`else
               quotient  <= acc;
               remainder <= rem;
`endif
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               // The divide-by-zero path arrives with out_valid low; raise it one clock later
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: directed vectors. Expected results are queued
// when an operation is issued, and monitors compare them on each output handshake.
module tb_seq_divider;

   localparam int unsigned N = 32;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         dz;
      logic         ov;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;

   logic         in_valid, in_ready, is_signed, out_valid, out_ready;
   logic [N-1:0] dividend, divisor, quotient, remainder;
   logic         div_by_zero, overflow, busy;

   logic         in_valid4, in_ready4, is_signed4, out_valid4, out_ready4;
   logic [N-1:0] dividend4, divisor4, quotient4, remainder4;
   logic         div_by_zero4, overflow4, busy4;

   exp_t sb0[$];
   exp_t sb4[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   seq_divider #(.N(N), .STEPS(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero), .overflow(overflow), .busy(busy)
   );

   seq_divider #(.N(N), .STEPS(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .dividend(dividend4), .divisor(divisor4), .is_signed(is_signed4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .quotient(quotient4), .remainder(remainder4),
      .div_by_zero(div_by_zero4), .overflow(overflow4), .busy(busy4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor for the STEPS=1 divider
   always @(negedge clk) begin : mon0
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (sb0.size() == 0) begin
            check("mon0_unexpected_result", 32'(out_valid), 32'(0));
         end else begin
            e = sb0.pop_front();
            check("mon0_quotient", quotient, e.q);
            check("mon0_remainder", remainder, e.r);
            check("mon0_div_by_zero", 32'(div_by_zero), 32'(e.dz));
            check("mon0_overflow", 32'(overflow), 32'(e.ov));
         end
      end
   end

   // Scoreboard monitor for the STEPS=4 divider
   always @(negedge clk) begin : mon4
      exp_t e;
      if (rst_n && out_valid4 && out_ready4) begin
         if (sb4.size() == 0) begin
            check("mon4_unexpected_result", 32'(out_valid4), 32'(0));
         end else begin
            e = sb4.pop_front();
            check("mon4_quotient", quotient4, e.q);
            check("mon4_remainder", remainder4, e.r);
            check("mon4_div_by_zero", 32'(div_by_zero4), 32'(e.dz));
            check("mon4_overflow", 32'(overflow4), 32'(e.ov));
         end
      end
   end

   // Issue one operation on the STEPS=1 divider and measure its latency
   task automatic run0(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic sgn, input logic [N-1:0] eq, input logic [N-1:0] er,
                       input logic edz, input logic eov, input int exp_lat);
      exp_t e;
      int   g;
      int   lat;
      g = 0;
      @(negedge clk);
      while (!in_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      check({name, "_in_ready_before"}, 32'(in_ready), 32'(1));
      dividend  = a;
      divisor   = b;
      is_signed = sgn;
      in_valid  = 1'b1;
      e.q = eq; e.r = er; e.dz = edz; e.ov = eov;
      sb0.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = 'x;
      divisor  = 'x;
      check({name, "_busy"}, 32'(busy), 32'(1));
      check({name, "_in_ready_low"}, 32'(in_ready), 32'(0));
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
      end while (!out_valid && lat < 200);
      if (exp_lat > 0) check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      else check({name, "_out_valid_seen"}, 32'(out_valid), 32'(1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      rst_n      = 1'b0;
      in_valid   = 1'b0;  in_valid4  = 1'b0;
      dividend   = '0;    divisor    = '0;    is_signed  = 1'b0;
      dividend4  = '0;    divisor4   = '0;    is_signed4 = 1'b0;
      out_ready  = 1'b1;  out_ready4 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_in_ready", 32'(in_ready), 32'(1));
      check("reset_out_valid", 32'(out_valid), 32'(0));
      check("reset_busy", 32'(busy), 32'(0));
      check("reset_quotient", quotient, 32'(0));
      check("reset_remainder", remainder, 32'(0));
      check("reset_flags", {30'b0, div_by_zero, overflow}, 32'(0));
      rst_n = 1'b1;

      run0("u100_10", 32'd100, 32'd10, 1'b0, 32'd10, 32'd0, 1'b0, 1'b0, 0);
      run0("u16_3", 32'd16, 32'd3, 1'b0, 32'd5, 32'd1, 1'b0, 1'b0, 33);
      run0("u5_7", 32'd5, 32'd7, 1'b0, 32'd0, 32'd5, 1'b0, 1'b0, 33);
      run0("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 33);
      run0("u1000000_3", 32'd1000000, 32'd3, 1'b0, 32'd333333, 32'd1, 1'b0, 1'b0, 33);
      run0("div0", 32'd7, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd7, 1'b1, 1'b0, 1);
      // dz flag must clear on the next accept
      run0("after_div0", 32'd9, 32'd2, 1'b0, 32'd4, 32'd1, 1'b0, 1'b0, 33);
`ifdef DIVIDER_SIGNED_EN
      run0("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
      run0("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 33);
      run0("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 33);
      run0("s_clear_ovf", 32'd20, 32'd6, 1'b1, 32'd3, 32'd2, 1'b0, 1'b0, 33);
`else
      run0("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0, 33);
      run0("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 1'b0, 1'b0, 33);
      run0("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 33);
      run0("s_clear_ovf", 32'd20, 32'd6, 1'b1, 32'd3, 32'd2, 1'b0, 1'b0, 33);
`endif
      is_signed = 1'b0;

      // STEPS=4 with backpressure: result must stay stable while out_ready is low
      @(negedge clk);
      check("s4_in_ready_before", 32'(in_ready4), 32'(1));
      dividend4 = 32'd255;
      divisor4  = 32'd5;
      in_valid4 = 1'b1;
      sb4.push_back('{q: 32'd51, r: 32'd0, dz: 1'b0, ov: 1'b0});
      @(posedge clk);
      #1;
      in_valid4 = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
      end while (!out_valid4 && lat < 100);
      check("s4_latency", 32'(lat), 32'(9));
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("s4_hold_valid", 32'(out_valid4), 32'(1));
         check("s4_hold_quotient", quotient4, 32'd51);
         check("s4_hold_remainder", remainder4, 32'd0);
         check("s4_hold_in_ready", 32'(in_ready4), 32'(0));
      end
      out_ready4 = 1'b1;
      @(posedge clk);
      #1;
      check("s4_in_ready_return", 32'(in_ready4), 32'(1));
      check("s4_out_valid_drop", 32'(out_valid4), 32'(0));

      // Reset during CALC aborts the operation with no result
      @(negedge clk);
      dividend = 32'd123456;
      divisor  = 32'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("rst_mid_busy_before", 32'(busy), 32'(1));
      rst_n = 1'b0;
      #1;
      check("rst_mid_in_ready", 32'(in_ready), 32'(1));
      check("rst_mid_out_valid", 32'(out_valid), 32'(0));
      check("rst_mid_busy", 32'(busy), 32'(0));
      check("rst_mid_quotient", quotient, 32'(0));
      check("rst_mid_remainder", remainder, 32'(0));
      check("rst_mid_flags", {30'b0, div_by_zero, overflow}, 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("rst_mid_no_result", 32'(out_valid), 32'(0));
      run0("u90_9", 32'd90, 32'd9, 1'b0, 32'd10, 32'd0, 1'b0, 1'b0, 33);

      repeat (3) @(posedge clk);
      #1;
      check("sb0_drained", 32'(sb0.size()), 32'(0));
      check("sb4_drained", 32'(sb4.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
